// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - MEM-stage load/store initiator for the data-RAM port
// Single outstanding request: checks funct3/alignment/range, strobes the RAM, returns a held response.
module lsu_mem_master #(
  parameter int MEM_BYTES = 8192,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [2:0]       req_funct3_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic             resp_misalign_o,
  output logic             resp_range_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  output logic [2:0]       mem_size_o,
  input  logic [31:0]      mem_data_i,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o,
  output logic [CNT_W-1:0] fault_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_RESP} state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

  state_e           state_q, state_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [2:0]       mem_size_q, mem_size_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_mis_q, resp_mis_d;
  logic             resp_rng_q, resp_rng_d;
  logic             we_q, we_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  logic funct3_ok, is_half, is_word, range_err, misalign;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Stores have no unsigned variants, so bu/hu codes are illegal for them.
  always_comb begin
    funct3_ok = req_we_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_half   = (req_funct3_i == 3'b001) || (req_funct3_i == 3'b101);
    is_word   = (req_funct3_i == 3'b010);
    range_err = !funct3_ok || (req_addr_i >= ADDR_LIMIT);
    misalign  = (is_half && req_addr_i[0]) || (is_word && (req_addr_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_size_d   = mem_size_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_mis_d   = resp_mis_q;
    resp_rng_d   = resp_rng_q;
    we_d         = we_q;
    fault_d      = fault_q;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          resp_data_d = '0;
          resp_mis_d  = misalign;
          resp_rng_d  = range_err;
          if (misalign || range_err) begin
            // Faulted requests never touch the RAM port, not even its address.
            fault_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            fault_d    = 1'b0;
            mem_addr_d = req_addr_i;
            mem_data_d = req_wdata_i;
            mem_size_d = req_funct3_i;
            mem_we_d   = req_we_i;
            mem_re_d   = !req_we_i;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        resp_data_d  = mem_data_i;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
          if (fault_q)   fault_cnt_d = sat_inc(fault_cnt_q);
          else if (we_q) store_cnt_d = sat_inc(store_cnt_q);
          else           load_cnt_d  = sat_inc(load_cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_size_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_rng_q   <= 1'b0;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      fault_cnt_q  <= '0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_size_q   <= mem_size_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_mis_q   <= resp_mis_d;
      resp_rng_q   <= resp_rng_d;
      we_q         <= we_d;
      fault_q      <= fault_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE) && rst_n;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign resp_misalign_o = resp_mis_q;
  assign resp_range_o    = resp_rng_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign mem_size_o      = mem_size_q;
  assign mem_we_o        = mem_we_q;
  assign mem_re_o        = mem_re_q;
  assign load_cnt_o      = load_cnt_q;
  assign store_cnt_o     = store_cnt_q;
  assign fault_cnt_o     = fault_cnt_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master with a lane-placing RAM model
// A second instance with 2-bit counters shares all inputs to exercise counter saturation.
module tb_lsu_mem_master;

  localparam int MEM_BYTES = 8192;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata, mem_data_i;
  logic [2:0]  req_f3;

  logic        req_ready_o, resp_valid_o, resp_mis_o, resp_rng_o, mem_we_o, mem_re_o;
  logic [31:0] resp_data_o, mem_addr_o, mem_data_o;
  logic [2:0]  mem_size_o;
  logic [15:0] load_cnt_o, store_cnt_o, fault_cnt_o;

  logic        s_req_ready, s_resp_valid, s_resp_mis, s_resp_rng, s_mem_we, s_mem_re;
  logic [31:0] s_resp_data, s_mem_addr, s_mem_data;
  logic [2:0]  s_mem_size;
  logic [1:0]  s_load_cnt, s_store_cnt, s_fault_cnt;

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_data_o(resp_data_o),
    .resp_misalign_o(resp_mis_o), .resp_range_o(resp_rng_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_size_o(mem_size_o), .mem_data_i(mem_data_i),
    .load_cnt_o(load_cnt_o), .store_cnt_o(store_cnt_o), .fault_cnt_o(fault_cnt_o)
  );

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3),
    .resp_valid_o(s_resp_valid), .resp_ready_i(resp_ready), .resp_data_o(s_resp_data),
    .resp_misalign_o(s_resp_mis), .resp_range_o(s_resp_rng),
    .mem_addr_o(s_mem_addr), .mem_data_o(s_mem_data), .mem_we_o(s_mem_we),
    .mem_re_o(s_mem_re), .mem_size_o(s_mem_size), .mem_data_i(mem_data_i),
    .load_cnt_o(s_load_cnt), .store_cnt_o(s_store_cnt), .fault_cnt_o(s_fault_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        rng;
    logic        flt;
    logic        we;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [31:0] ram_w [0:2047];
  int          n_vec = 0, n_fail = 0;
  int          cyc = 0;
  int          ld = 0, st = 0, ft = 0;
  int          we_p = 0, re_p = 0;
  int          hold = 0;
  bit          in_resp = 0, rst_phase = 0;
  logic [31:0] snap_data;
  logic        snap_mis, snap_rng;
  exp_t        cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat2(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  // RAM: word array, lane placement by address, sign/zero extension by size code.
  logic [10:0] r_idx;
  logic [4:0]  r_sh;
  logic [31:0] r_mask, r_w;
  always @(posedge clk) begin
    r_idx = mem_addr_o[12:2];
    r_sh  = {mem_addr_o[1:0], 3'b000};
    r_mask = (mem_size_o[1:0] == 2'b00) ? 32'h0000_00FF :
             (mem_size_o[1:0] == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    if (mem_we_o)
      ram_w[r_idx] = (ram_w[r_idx] & ~(r_mask << r_sh)) | ((mem_data_o & r_mask) << r_sh);
    if (mem_re_o) begin
      r_w = ram_w[r_idx] >> r_sh;
      case (mem_size_o)
        3'b000:  mem_data_i <= {{24{r_w[7]}}, r_w[7:0]};
        3'b100:  mem_data_i <= {24'h0, r_w[7:0]};
        3'b001:  mem_data_i <= {{16{r_w[15]}}, r_w[15:0]};
        3'b101:  mem_data_i <= {16'h0, r_w[15:0]};
        default: mem_data_i <= r_w;
      endcase
    end
  end

  // Reference: byte-addressed memory and the architectural load/store rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output exp_t e);
    bit legal, half, word;
    int nb;
    logic [31:0] v;
    legal = we ? (f3 == 0 || f3 == 1 || f3 == 2)
               : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    half  = (f3 == 1 || f3 == 5);
    word  = (f3 == 2);
    nb    = word ? 4 : (half ? 2 : 1);
    e.rng = !legal || (addr >= MEM_BYTES);
    e.mis = (half && (addr % 2 != 0)) || (word && (addr % 4 != 0));
    e.flt = e.rng || e.mis;
    e.we  = we;
    e.lat = e.flt ? 1 : (we ? 2 : 3);
    e.data = 32'h0;
    if (!e.flt && we) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else if (!e.flt) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
      e.data = v;
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hd);
    exp_t e;
    bit done;
    done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_f3 = f3;
    for (int n = 0; n < 64 && !done; n++) begin
      if (req_ready_o) begin
        model(we, addr, wd, f3, e);
        e.acc  = cyc + 1;
        e.hold = hd;
        sb.push_back(e);
        done = 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: req_ready_o never rose for addr 0x%08h", addr);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_resp && req_ready_o) done = 1;
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
    end
  endtask

  // Monitor: pops the scoreboard on each new response and paces resp_ready.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || rst_phase) continue;
      if (mem_we_o || mem_re_o) chk("strobe_excl", {31'b0, mem_we_o & mem_re_o}, 32'h0);
      we_p += int'(mem_we_o);
      re_p += int'(mem_re_o);
      if (resp_valid_o) begin
        if (!in_resp) begin
          in_resp = 1;
          if (sb.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_resp: data 0x%08h with empty scoreboard", resp_data_o);
            cur.flt = 1'b1; cur.we = 1'b0; hold = 0;
          end else begin
            cur = sb.pop_front();
            chk("resp_data", resp_data_o, cur.data);
            chk("resp_misalign", {31'b0, resp_mis_o}, {31'b0, cur.mis});
            chk("resp_range", {31'b0, resp_rng_o}, {31'b0, cur.rng});
            chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
            chk("we_pulses", 32'(we_p), (cur.we && !cur.flt) ? 32'd1 : 32'd0);
            chk("re_pulses", 32'(re_p), (!cur.we && !cur.flt) ? 32'd1 : 32'd0);
            chk("ready_in_resp", {31'b0, req_ready_o}, 32'h0);
            chk("load_cnt", {16'h0, load_cnt_o}, 32'(ld));
            chk("store_cnt", {16'h0, store_cnt_o}, 32'(st));
            chk("fault_cnt", {16'h0, fault_cnt_o}, 32'(ft));
            chk("sat_load_cnt", {30'h0, s_load_cnt}, sat2(ld));
            chk("sat_store_cnt", {30'h0, s_store_cnt}, sat2(st));
            chk("sat_fault_cnt", {30'h0, s_fault_cnt}, sat2(ft));
            hold = cur.hold;
          end
          snap_data = resp_data_o; snap_mis = resp_mis_o; snap_rng = resp_rng_o;
          we_p = 0; re_p = 0;
        end else begin
          chk("hold_data", resp_data_o, snap_data);
          chk("hold_flags", {30'h0, resp_mis_o, resp_rng_o}, {30'h0, snap_mis, snap_rng});
          chk("hold_ready", {31'b0, req_ready_o}, 32'h0);
        end
        if (hold == 0) begin
          if (!resp_ready) begin
            if (cur.flt)     ft++;
            else if (cur.we) st++;
            else             ld++;
          end
          resp_ready = 1'b1;
        end else begin
          hold--;
        end
      end else begin
        in_resp = 0;
        resp_ready = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h0;
    for (int i = 0; i < 2048; i++) ram_w[i] = 32'h0;
    mem_data_i = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_f3 = 3'b000;
    @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'h0);
    chk("rst_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_resp_data", resp_data_o, 32'h0);
    chk("rst_counters", {load_cnt_o | store_cnt_o | fault_cnt_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready_o}, 32'h1);

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0);
    do_req(1'b1, 32'h20, 32'h0000_80FF, 3'b010, 0);
    do_req(1'b0, 32'h20, 32'h0, 3'b000, 0);
    do_req(1'b0, 32'h20, 32'h0, 3'b100, 1);
    do_req(1'b0, 32'h20, 32'h0, 3'b001, 0);
    do_req(1'b0, 32'h22, 32'h0, 3'b101, 2);
    do_req(1'b0, 32'h12, 32'h0, 3'b010, 0);
    do_req(1'b1, 32'h2001, 32'h1234, 3'b001, 0);
    drain();
    chk("fault_cnt_after_faults", {16'h0, fault_cnt_o}, 32'd2);
    do_req(1'b1, 32'h40, 32'h5555_AAAA, 3'b100, 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 5);
    do_req(1'b0, 32'h20, 32'h0, 3'b000, 0);
    drain();

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
      if ($urandom_range(0, 15) == 0) addr = 32'h2000 + 32'($urandom_range(0, 64));
      else addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 3'b010) addr = addr & ~32'h3;
        else if (f3[0]) addr = addr & ~32'h1;
      end
      do_req(we, addr, $urandom, f3, $urandom_range(0, 2));
    end
    drain();

    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0);
    @(posedge clk);
    #2;
    rst_phase = 1;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
    chk("midrst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("midrst_ready", {31'b0, req_ready_o}, 32'h0);
    chk("midrst_counters", {load_cnt_o | store_cnt_o | fault_cnt_o}, 32'h0);
    sb.delete();
    ld = 0; st = 0; ft = 0; we_p = 0; re_p = 0; hold = 0;
    in_resp = 0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_phase = 0;
    @(negedge clk);
    chk("postrst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("postrst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("postrst_counters", {load_cnt_o | store_cnt_o | fault_cnt_o}, 32'h0);
    for (int i = 0; i < 5; i++) do_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 3'b010, 0);
    drain();
    chk("store_cnt_5", {16'h0, store_cnt_o}, 32'd5);
    chk("sat_store_cnt_5", {30'h0, s_store_cnt}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
